// File: rtl/floor_scheduler.sv
// Single-car SCAN elevator: latches floor calls, steps a one-hot car position, dwells at requested floors.
// Latency: a request acts one edge after it latches; each hop takes TRAVEL_TICKS edges, each stop DOOR_TICKS cycles.
// Backpressure: none; req is sampled on every edge and held in pending until that floor is serviced.
module floor_scheduler #(
  parameter int FLOORS       = 6,
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] req,
  output logic [FLOORS-1:0] floor,
  output logic [FLOORS-1:0] pending,
  output logic              above,
  output logic              below,
  output logic              here,
  output logic              up,
  output logic              down,
  output logic              door_open
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] DOOR = 2'd2;

  localparam int MAXT = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CW   = (MAXT < 2) ? 1 : $clog2(MAXT + 1);
  localparam logic [CW-1:0] T_LOAD = CW'(TRAVEL_TICKS - 1);
  localparam logic [CW-1:0] D_LOAD = CW'(DOOR_TICKS - 1);

  logic [1:0]        state, state_nx;
  logic              dir, dir_nx;         // 1 = up
  logic              last_dir, last_dir_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [FLOORS-1:0] floor_nx;
  logic [FLOORS-1:0] clr;
  logic [FLOORS-1:0] mask_lt;             // floors strictly below the car
  logic [FLOORS-1:0] mask_le;             // floors at or below the car
  logic [FLOORS-1:0] next_floor;
  logic [FLOORS-1:0] pend_in;

  // One-hot minus one gives every bit below the car; these feed the pending-set comparisons.
  always_comb begin
    mask_lt    = floor - FLOORS'(1);
    mask_le    = mask_lt | floor;
    above      = |(pending & ~mask_le);
    below      = |(pending & mask_lt);
    here       = |(pending & floor);
    next_floor = dir ? (floor << 1) : (floor >> 1);
    pend_in    = pending | req;
  end

  // SCAN decisions: serve here first, prefer the last travel direction, stop at any pending floor on arrival.
  always_comb begin
    state_nx    = state;
    dir_nx      = dir;
    last_dir_nx = last_dir;
    cnt_nx      = cnt;
    floor_nx    = floor;
    clr         = '0;
    case (state)
      IDLE: begin
        if (here) begin
          state_nx = DOOR;
          clr      = floor;
          cnt_nx   = D_LOAD;
        end else if (above && (last_dir || !below)) begin
          state_nx = MOVE;
          dir_nx   = 1'b1;
          cnt_nx   = T_LOAD;
        end else if (below) begin
          state_nx = MOVE;
          dir_nx   = 1'b0;
          cnt_nx   = T_LOAD;
        end
      end
      MOVE: begin
        if (cnt == '0) begin
          floor_nx    = next_floor;
          last_dir_nx = dir;
          if (|(next_floor & pend_in)) begin
            state_nx = DOOR;
            clr      = next_floor;
            cnt_nx   = D_LOAD;
          end else begin
            cnt_nx = T_LOAD;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      DOOR: begin
        // A fresh call for the open floor just holds the door; it never becomes pending.
        if (|(req & floor)) begin
          clr    = floor;
          cnt_nx = D_LOAD;
        end else if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, position and request registers; status outputs decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dir       <= 1'b1;
      last_dir  <= 1'b1;
      cnt       <= '0;
      floor     <= FLOORS'(1);
      pending   <= '0;
      up        <= 1'b0;
      down      <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state     <= state_nx;
      dir       <= dir_nx;
      last_dir  <= last_dir_nx;
      cnt       <= cnt_nx;
      floor     <= floor_nx;
      pending   <= pend_in & ~clr;
      up        <= (state_nx == MOVE) && dir_nx;
      down      <= (state_nx == MOVE) && !dir_nx;
      door_open <= (state_nx == DOOR);
    end
  end

endmodule

// File: doc/floor_scheduler.md
# floor_scheduler

Parametrised single-car elevator controller for an N-floor building. It latches floor-call requests, tracks the car position as a one-hot floor vector, and generalises the one-hot-vs-request greater/lesser/equal comparison across the whole pending set (above/below/here). A SCAN-style FSM moves the car one floor per travel interval and opens the door for a fixed dwell at each requested floor. It sits between the debounced call-button inputs and the floor/direction/door display logic.

## Interface
- FLOORS, 6: number of floors; width of all floor vectors; must be ≥ 2.
- TRAVEL_TICKS, 4: cycles spent in MOVE per one-floor hop; must be ≥ 1.
- DOOR_TICKS, 3: cycles door_open stays high per stop; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset  in  1  synchronous, active-high.
- req  in  FLOORS  call requests, any number of bits; sampled every edge.
- floor  out  FLOORS  current car position, always exactly one bit set.
- pending  out  FLOORS  latched, not-yet-serviced requests.
- above  out  1  combinational: any pending bit strictly above floor.
- below  out  1  combinational: any pending bit strictly below floor.
- here  out  1  combinational: pending bit at floor.
- up  out  1  car moving toward higher floors (MOVE state, dir=up).
- down  out  1  car moving toward lower floors (MOVE state, dir=down).
- door_open  out  1  high in DOOR state only.

## Operation
- Reset values: floor = 1 (floor 0), pending = 0, state IDLE, last_dir = up, up/down/door_open = 0, counters = 0.
- Pending update each edge: pending <= (pending | req) & ~clr. clr = the floor bit being serviced on a DOOR-entry edge. Clear wins over a simultaneous req for that floor.
- States: IDLE, MOVE, DOOR.
- IDLE:
  - here → DOOR; clear that bit; load DOOR_TICKS.
  - else if above and (last_dir = up or !below) → MOVE, dir = up.
  - else if below → MOVE, dir = down.
  - else stay IDLE.
  - If both directions have requests, last_dir wins.
- MOVE:
  - Travel counter runs TRAVEL_TICKS cycles.
  - On the edge ending the final cycle, floor shifts one bit (left for up, right for down) and last_dir <= dir.
  - Arrival decision on the same edge uses the next floor:
    - pending at next floor (including a req at that edge) → DOOR; clear the bit.
    - else → stay in MOVE; reload counter; keep dir.
- DOOR:
  - door_open = 1 for DOOR_TICKS cycles, then IDLE.
  - A req for the current floor during DOOR reloads the dwell counter and is not latched into pending.
- Requests latch in any state. A req for the current floor during MOVE (car not yet shifted) stays pending and is served on a later pass.
- Boundary: floor never shifts below bit 0 or above bit FLOORS-1. MOVE is only entered with a request in that direction, and requests are only removed by service. Bench asserts this invariant.
- Reset mid-operation: all state returns to reset values on the next edge; pending requests are discarded.
- above/below/here are pure combinational decodes of registered floor and pending.

## Timing
- State, floor, pending, up/down/door_open are registered. up/down/door_open are decoded from state only.
- req at edge E1 → pending visible after E1 → FSM acts on E2.
- IDLE → MOVE: up/down high from E2. First floor change at E2+TRAVEL_TICKS. Each further hop takes TRAVEL_TICKS edges.
- Arrival → door_open high in the cycle immediately after the arrival edge, for exactly DOOR_TICKS cycles; IDLE after that.
- Minimum IDLE dwell between DOOR exit and the next MOVE: 1 cycle (decision cycle).

## Test plan
- Reset: assert reset 2 cycles with req = 6'b111111 → floor = 000001, pending = 0, up = down = door_open = 0.
- Single trip (FLOORS=6, T=4, D=3): req = 001000 for one cycle at E1:
  - up high from E2.
  - floor = 000010 at E6, 000100 at E10, 001000 at E14.
  - door_open high for 3 cycles after E14; IDLE at E17; pending = 0.
- Same-floor call: idle at floor 0, req = 000001 → DOOR at E2, no movement. Repeat req during dwell → door_open extends 3 cycles from the re-request edge; pending stays 0.
- Intermediate stop: car moving up from floor 2 to pending floor 5; req floor 3 mid-hop → stops at 3 (door 3 cycles), then continues to 5.
- Direction preference: at floor 2 with last_dir = up, pending = 010010 (floors 1 and 4) → serves 4 first, then reverses and serves 1; down high only on the return trip.
- Reset mid-MOVE between floors 1 and 2 with pending = 100000 → next edge: floor = 000001, pending = 0, IDLE, up = 0.
